// File: rtl/axis_block_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_packer_if
// Purpose  : AXI-Stream bundle with master/slave views for the block packer.
// Revision : 1.0
// ============================================================================
interface axis_block_packer_if #(
    parameter int TDATA_WIDTH = 128
);
    localparam int NB = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [NB-1:0]          tkeep;
    logic                   tlast;
    logic                   tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_packer
// Purpose  : Repacks byte-granular AXI-Stream beats into dense full-width blocks.
// Revision : 1.0
// ============================================================================
module axis_block_packer #(
    parameter int TDATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_block_packer_if.slave    s_axis,
    axis_block_packer_if.master   m_axis
);
    localparam int NB = TDATA_WIDTH / 8;
    localparam int BW = 2 * TDATA_WIDTH;
    localparam int CW = $clog2(2 * NB + 1);

    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_pend_q, last_pend_d;
    logic          in_pkt_q, in_pkt_d;
    logic          tuser_q, tuser_d;

    logic                   in_hs, out_hs;
    logic                   m_tvalid, m_tlast, s_tready;
    logic [NB-1:0]          m_tkeep;
    logic [CW-1:0]          n, k, off;
    logic [TDATA_WIDTH-1:0] keep_bits;
    logic [BW-1:0]          in_data, in_mask;

    always_comb begin
        n         = '0;
        keep_bits = '0;
        m_tkeep   = '0;
        for (int i = 0; i < NB; i++) begin
            n                 = n + CW'(s_axis.tkeep[i]);
            keep_bits[8*i +: 8] = {8{s_axis.tkeep[i]}};
            m_tkeep[i]        = (CW'(i) < cnt_q);
        end
    end

    // Output side depends only on registered state; s_tready is gated by
    // rst_n so it stays low while reset is held.
    assign m_tvalid = (cnt_q >= CW'(NB)) | last_pend_q;
    assign m_tlast  = last_pend_q & (cnt_q <= CW'(NB));
    assign s_tready = rst_n & (cnt_q <= CW'(NB)) & ~last_pend_q;

    assign in_hs  = s_axis.tvalid & s_tready;
    assign out_hs = m_tvalid & m_axis.tready;

    assign k   = out_hs ? ((cnt_q >= CW'(NB)) ? CW'(NB) : cnt_q) : '0;
    assign off = cnt_q - k;

    assign in_data = {{TDATA_WIDTH{1'b0}}, s_axis.tdata & keep_bits} << {off, 3'b000};
    assign in_mask = {{TDATA_WIDTH{1'b0}}, keep_bits} << {off, 3'b000};

    always_comb begin
        buf_d       = buf_q >> {k, 3'b000};
        cnt_d       = cnt_q - k;
        last_pend_d = last_pend_q;
        in_pkt_d    = in_pkt_q;
        tuser_d     = tuser_q;

        if (out_hs && m_tlast) begin
            last_pend_d = 1'b0;
        end

        if (in_hs) begin
            buf_d = (buf_d & ~in_mask) | in_data;
            cnt_d = cnt_d + n;
            if (!in_pkt_q) begin
                tuser_d  = s_axis.tuser;
                in_pkt_d = 1'b1;
            end
            if (s_axis.tlast) begin
                last_pend_d = 1'b1;
                in_pkt_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            in_pkt_q    <= in_pkt_d;
            tuser_q     <= tuser_d;
        end
    end

    assign s_axis.tready = s_tready;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tdata  = buf_q[TDATA_WIDTH-1:0];
    assign m_axis.tkeep  = m_tkeep;
    assign m_axis.tlast  = m_tlast;
    assign m_axis.tuser  = tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_block_packer
// Purpose  : Directed and randomized scoreboard bench for axis_block_packer.
// Revision : 1.0
// ============================================================================
module tb_axis_block_packer;
    localparam int W  = 128;
    localparam int NB = W / 8;

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];
    typedef struct {
        logic [W-1:0]  data;
        logic [NB-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_block_packer_if #(.TDATA_WIDTH(W)) s_if();
    axis_block_packer_if #(.TDATA_WIDTH(W)) m_if();

    axis_block_packer #(.TDATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] kmask(input logic [NB-1:0] k);
        logic [W-1:0] m = '0;
        for (int j = 0; j < NB; j++) m[8*j +: 8] = {8{k[j]}};
        return m;
    endfunction

    // Reference packing: consecutive NB-byte chunks, tlast on the final chunk.
    task automatic push_exp(input bq_t bytes, input logic user);
        beat_t e;
        int    o = 0;
        int    len = bytes.size();
        do begin
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < NB; j++) begin
                if (o + j < len) begin
                    e.data[8*j +: 8] = bytes[o + j];
                    e.keep[j] = 1'b1;
                end
            end
            o += NB;
            e.last = (o >= len);
            e.user = user;
            exp_q.push_back(e);
        end while (o < len);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic drive_beat(input logic [W-1:0] d, input logic [NB-1:0] k,
                              input logic last, input logic user, output int waits);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = last;
        s_if.tuser  = user;
        waits = 0;
        @(negedge clk);
        while (!s_if.tready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 500) chk("s_tready_timeout", s_if.tready, 1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drive_pkt(input bq_t bytes, input iq_t lens, input logic user, input bit gaps);
        int idx = 0;
        int w;
        logic [W-1:0]  d;
        logic [NB-1:0] k;
        for (int b = 0; b < lens.size(); b++) begin
            while (gaps && ($urandom_range(0, 1) == 1)) begin
                @(posedge clk);
                #1;
            end
            d = '0;
            k = '0;
            for (int j = 0; j < lens[b]; j++) begin
                d[8*j +: 8] = bytes[idx + j];
                k[j] = 1'b1;
            end
            drive_beat(d, k, (b == lens.size() - 1), user, w);
            idx += lens[b];
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_size", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_if.tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Output monitor: scoreboard pop on handshake, hold check on back-pressure.
    logic          held = 1'b0;
    logic [W-1:0]  h_data;
    logic [NB-1:0] h_keep;
    logic          h_last, h_user;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_tvalid", m_if.tvalid, 1);
                chk("hold_tdata",  m_if.tdata & kmask(h_keep), h_data & kmask(h_keep));
                chk("hold_tkeep",  m_if.tkeep, h_keep);
                chk("hold_tlast",  m_if.tlast, h_last);
                chk("hold_tuser",  m_if.tuser, h_user);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_queue_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tkeep", m_if.tkeep, e.keep);
                    chk("out_tlast", m_if.tlast, e.last);
                    chk("out_tuser", m_if.tuser, e.user);
                    chk("out_tdata", m_if.tdata & kmask(e.keep), e.data);
                end
            end
            held   = m_if.tvalid && !m_if.tready;
            h_data = m_if.tdata;
            h_keep = m_if.tkeep;
            h_last = m_if.tlast;
            h_user = m_if.tuser;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  bytes;
        iq_t  lens;
        int   w, wsum, hi_cnt, nb, ln, tot;
        logic [W-1:0] d;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        #12;
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tkeep",  m_if.tkeep, 0);
        chk("rst_m_tlast",  m_if.tlast, 0);
        chk("rst_m_tuser",  m_if.tuser, 0);
        chk("rst_m_tdata",  m_if.tdata, 0);
        chk("rst_s_tready", s_if.tready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_tready", s_if.tready, 1);
        @(posedge clk);
        #1;

        // Three full beats, back-to-back, one cycle latency
        m_if.tready = 1'b1;
        bytes = {};
        for (int i = 0; i < 48; i++) bytes.push_back(8'(i));
        push_exp(bytes, 1'b0);
        wsum = 0;
        for (int b = 0; b < 3; b++) begin
            d = '0;
            for (int j = 0; j < NB; j++) d[8*j +: 8] = bytes[16*b + j];
            drive_beat(d, '1, (b == 2), 1'b0, w);
            wsum += w;
            chk("t1_latency_tvalid", m_if.tvalid, 1);
            chk("t1_latency_tdata", m_if.tdata, d);
        end
        chk("t1_input_stall_cycles", wsum, 0);
        drain();

        // 5 + 16 + 3 bytes
        bytes = {};
        for (int i = 0; i < 24; i++) bytes.push_back(8'(i));
        push_exp(bytes, 1'b0);
        drive_pkt(bytes, '{5, 16, 3}, 1'b0, 1'b0);
        drain();

        // Zero-length packet with tuser=1, then a tuser=0 packet
        bytes = {};
        push_exp(bytes, 1'b1);
        drive_pkt(bytes, '{0}, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) bytes.push_back(8'(8'hA0 + i));
        push_exp(bytes, 1'b0);
        drive_pkt(bytes, '{16}, 1'b0, 1'b0);
        drain();

        // Back-pressure: two beats fill the buffer, third stalls
        m_if.tready = 1'b0;
        bytes = {};
        for (int i = 0; i < 48; i++) bytes.push_back(8'(8'h40 + i));
        push_exp(bytes, 1'b1);
        for (int b = 0; b < 2; b++) begin
            d = '0;
            for (int j = 0; j < NB; j++) d[8*j +: 8] = bytes[16*b + j];
            drive_beat(d, '1, 1'b0, 1'b1, w);
        end
        chk("t4_s_tready_after_two", s_if.tready, 0);
        d = '0;
        for (int j = 0; j < NB; j++) d[8*j +: 8] = bytes[32 + j];
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = '1;
        s_if.tlast  = 1'b1;
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_if.tready) hi_cnt++;
        end
        chk("t4_s_tready_high_cycles", hi_cnt, 0);
        chk("t4_m_tvalid_stalled", m_if.tvalid, 1);
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        drive_beat(d, '1, 1'b1, 1'b1, w);
        drain();

        // Random traffic, 50% valid gaps and ready
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            bytes = {};
            lens  = {};
            nb = $urandom_range(1, 4);
            tot = 0;
            for (int b = 0; b < nb; b++) begin
                ln = (nb == 1) ? $urandom_range(0, 16) : $urandom_range(1, 16);
                lens.push_back(ln);
                tot += ln;
            end
            for (int i = 0; i < tot; i++) bytes.push_back(8'($urandom));
            push_exp(bytes, 1'($urandom_range(0, 1)));
            drive_pkt(bytes, lens, exp_q[exp_q.size() - 1].user, 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        drain();

        // Asynchronous reset with a partial packet buffered
        m_if.tready = 1'b0;
        d = '0;
        for (int j = 0; j < NB; j++) d[8*j +: 8] = 8'(8'hC0 + j);
        drive_beat(d, '1, 1'b0, 1'b1, w);
        drive_beat(d, 16'h007F, 1'b0, 1'b1, w);
        chk("t6_pre_rst_m_tvalid", m_if.tvalid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_m_tvalid", m_if.tvalid, 0);
        chk("t6_async_s_tready", s_if.tready, 0);
        chk("t6_async_m_tkeep",  m_if.tkeep, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        bytes = {};
        for (int i = 0; i < 16; i++) bytes.push_back(8'(8'h70 + i));
        push_exp(bytes, 1'b0);
        drive_pkt(bytes, '{16}, 1'b0, 1'b0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("t6_idle_m_tvalid", m_if.tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
